sum_accumulator: RTL and testbench

SUM_ACCUMULATOR -- requirements
Module: sum_accumulator

---
 rtl/sum_accumulator.sv | 75 +++++++
 tb/tb_sum_accumulator.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/sum_accumulator.sv
// Frame accumulator: sums N_SAMPLES 5-bit adder results into an ACC_W-bit total,
// with a sticky wrap flag and a valid/ready handshake on the completed frame.
module sum_accumulator #(
  parameter int N_SAMPLES = 4,
  parameter int ACC_W     = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic             start,
  input  logic [4:0]       Q,
  input  logic             q_valid,
  input  logic             acc_ready,
  output logic [ACC_W-1:0] acc_out,
  output logic             acc_valid,
  output logic             busy,
  output logic             overflow
);

  localparam int CNT_W = 8;
  localparam int SUM_W = ACC_W + 1;

  typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;

  state_t             state, state_nxt;
  logic [CNT_W-1:0]   cnt;
  logic               frame_start;
  logic               accept;
  logic               last_sample;
  logic [SUM_W-1:0]   sum_ext;

  assign frame_start = enable && start && (state == IDLE);
  assign accept      = enable && q_valid && (state == ACCUM);
  assign last_sample = accept && (cnt == CNT_W'(N_SAMPLES - 1));

  // The extra top bit is the carry out of the accumulator, feeding the sticky flag.
  assign sum_ext = {1'b0, acc_out} + SUM_W'(Q);

  // NOTE: registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // NOTE: state_nxt gets a default first so no path through the case infers a latch.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (frame_start)          state_nxt = ACCUM;
      ACCUM:   if (last_sample)          state_nxt = DONE;
      DONE:    if (enable && acc_ready)  state_nxt = IDLE;
      default:                           state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt      <= '0;
      acc_out  <= '0;
      overflow <= 1'b0;
    end else if (frame_start) begin
      cnt      <= '0;
      acc_out  <= '0;
      overflow <= 1'b0;
    end else if (accept) begin
      cnt     <= cnt + 1'b1;
      acc_out <= sum_ext[ACC_W-1:0];
      if (sum_ext[ACC_W]) overflow <= 1'b1;
    end
  end

  assign acc_valid = (state == DONE);
  assign busy      = (state != IDLE);

endmodule

// File: tb/tb_sum_accumulator.sv
// Self-checking bench: three configurations (default, ACC_W=6, N_SAMPLES=1) share
// stimulus; directed scenarios plus randomized frames against a frame-level model.
module tb_sum_accumulator;

  logic       clk = 1'b0;
  logic       rst, enable, start, q_valid, acc_ready;
  logic [4:0] Q;

  logic [7:0] acc0; logic v0, b0, o0;
  logic [5:0] acc1; logic v1, b1, o1;
  logic [7:0] acc2; logic v2, b2, o2;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  sum_accumulator u_dut (
    .clk(clk), .rst(rst), .enable(enable), .start(start), .Q(Q), .q_valid(q_valid),
    .acc_ready(acc_ready), .acc_out(acc0), .acc_valid(v0), .busy(b0), .overflow(o0));

  sum_accumulator #(.N_SAMPLES(4), .ACC_W(6)) u_w6 (
    .clk(clk), .rst(rst), .enable(enable), .start(start), .Q(Q), .q_valid(q_valid),
    .acc_ready(acc_ready), .acc_out(acc1), .acc_valid(v1), .busy(b1), .overflow(o1));

  sum_accumulator #(.N_SAMPLES(1), .ACC_W(8)) u_n1 (
    .clk(clk), .rst(rst), .enable(enable), .start(start), .Q(Q), .q_valid(q_valid),
    .acc_ready(acc_ready), .acc_out(acc2), .acc_valid(v2), .busy(b2), .overflow(o2));

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic begin_frame();
    enable = 1'b1; q_valid = 1'b0; start = 1'b1;
    cycle();
    start = 1'b0;
  endtask

  task automatic push(input logic [4:0] v);
    Q = v; q_valid = 1'b1;
    cycle();
    q_valid = 1'b0;
  endtask

  task automatic drain_all();
    q_valid = 1'b0; start = 1'b0; enable = 1'b1; acc_ready = 1'b1;
    cycle(); cycle();
    acc_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; enable = 1'b1; start = 1'b0; q_valid = 1'b0; Q = '0; acc_ready = 1'b0;
    #1;
    checks++; if (acc0 !== 8'd0) begin errors++; $display("FAIL reset_acc: got %0d expected 0", acc0); end
    checks++; if (v0 !== 1'b0)   begin errors++; $display("FAIL reset_valid: got %b expected 0", v0); end
    checks++; if (b0 !== 1'b0)   begin errors++; $display("FAIL reset_busy: got %b expected 0", b0); end
    checks++; if (o0 !== 1'b0)   begin errors++; $display("FAIL reset_ovf: got %b expected 0", o0); end
    checks++; if (acc1 !== 6'd0 || v2 !== 1'b0) begin errors++; $display("FAIL reset_others: acc1=%0d v2=%b expected 0/0", acc1, v2); end
    cycle(); cycle();
    rst = 1'b0;
    cycle();
  endtask

  task automatic test_basic();
    acc_ready = 1'b1;
    begin_frame();
    checks++; if (b0 !== 1'b1 || acc0 !== 8'd0) begin errors++; $display("FAIL basic_start: busy=%b acc=%0d expected 1/0", b0, acc0); end
    push(5'd6);
    checks++; if (v2 !== 1'b1 || acc2 !== 8'd6) begin errors++; $display("FAIL n1_single: valid=%b acc=%0d expected 1/6", v2, acc2); end
    checks++; if (v0 !== 1'b0 || acc0 !== 8'd6) begin errors++; $display("FAIL basic_partial: valid=%b acc=%0d expected 0/6", v0, acc0); end
    push(5'd14); push(5'd16); push(5'd16);
    checks++; if (v0 !== 1'b1 || acc0 !== 8'd52) begin errors++; $display("FAIL basic_done: valid=%b acc=%0d expected 1/52", v0, acc0); end
    checks++; if (o0 !== 1'b0 || acc1 !== 6'd52 || o1 !== 1'b0) begin errors++; $display("FAIL basic_ovf: o0=%b acc1=%0d o1=%b expected 0/52/0", o0, acc1, o1); end
    cycle();
    checks++; if (b0 !== 1'b0 || v0 !== 1'b0 || acc0 !== 8'd52) begin errors++; $display("FAIL basic_idle: busy=%b valid=%b acc=%0d expected 0/0/52", b0, v0, acc0); end
    checks++; if (b2 !== 1'b0 || acc2 !== 8'd6) begin errors++; $display("FAIL n1_ignored: busy=%b acc=%0d expected 0/6", b2, acc2); end
    drain_all();
  endtask

  task automatic test_overflow();
    acc_ready = 1'b0;
    begin_frame();
    repeat (4) push(5'd30);
    checks++; if (acc1 !== 6'd56 || o1 !== 1'b1 || v1 !== 1'b1) begin errors++; $display("FAIL ovf_w6: acc=%0d ovf=%b valid=%b expected 56/1/1", acc1, o1, v1); end
    checks++; if (acc0 !== 8'd120 || o0 !== 1'b0) begin errors++; $display("FAIL ovf_w8: acc=%0d ovf=%b expected 120/0", acc0, o0); end
    acc_ready = 1'b1;
    cycle();
    acc_ready = 1'b0;
    checks++; if (b1 !== 1'b0 || acc1 !== 6'd56 || o1 !== 1'b1) begin errors++; $display("FAIL ovf_retain: busy=%b acc=%0d ovf=%b expected 0/56/1", b1, acc1, o1); end
    begin_frame();
    checks++; if (o1 !== 1'b0 || acc1 !== 6'd0) begin errors++; $display("FAIL ovf_clear: ovf=%b acc=%0d expected 0/0", o1, acc1); end
    repeat (4) push(5'd0);
    drain_all();
  endtask

  task automatic test_backpressure();
    acc_ready = 1'b0;
    begin_frame();
    push(5'd1); push(5'd2); push(5'd3); push(5'd4);
    for (int i = 0; i < 4; i++) begin
      checks++; if (v0 !== 1'b1 || acc0 !== 8'd10) begin errors++; $display("FAIL bp_hold%0d: valid=%b acc=%0d expected 1/10", i, v0, acc0); end
      start = (i == 1);
      if (i < 3) cycle();
    end
    start = 1'b1; acc_ready = 1'b1;
    cycle();
    start = 1'b0; acc_ready = 1'b0;
    checks++; if (b0 !== 1'b0 || v0 !== 1'b0) begin errors++; $display("FAIL bp_release: busy=%b valid=%b expected 0/0", b0, v0); end
    cycle();
    checks++; if (b0 !== 1'b0 || acc0 !== 8'd10) begin errors++; $display("FAIL bp_no_restart: busy=%b acc=%0d expected 0/10", b0, acc0); end
    drain_all();
  endtask

  task automatic test_enable_freeze();
    acc_ready = 1'b0;
    enable = 1'b0; start = 1'b1;
    cycle();
    start = 1'b0; enable = 1'b1;
    checks++; if (b0 !== 1'b0) begin errors++; $display("FAIL frz_idle_start: busy=%b expected 0", b0); end
    begin_frame();
    push(5'd5); push(5'd5);
    enable = 1'b0; q_valid = 1'b1; Q = 5'd31; acc_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      cycle();
      checks++; if (acc0 !== 8'd10 || b0 !== 1'b1 || v0 !== 1'b0) begin errors++; $display("FAIL frz_accum%0d: acc=%0d busy=%b valid=%b expected 10/1/0", i, acc0, b0, v0); end
    end
    enable = 1'b1; q_valid = 1'b0; acc_ready = 1'b0;
    push(5'd5); push(5'd5);
    checks++; if (v0 !== 1'b1 || acc0 !== 8'd20) begin errors++; $display("FAIL frz_total: valid=%b acc=%0d expected 1/20", v0, acc0); end
    enable = 1'b0; acc_ready = 1'b1;
    repeat (2) cycle();
    checks++; if (v0 !== 1'b1 || acc0 !== 8'd20) begin errors++; $display("FAIL frz_done: valid=%b acc=%0d expected 1/20", v0, acc0); end
    enable = 1'b1;
    cycle();
    acc_ready = 1'b0;
    checks++; if (b0 !== 1'b0) begin errors++; $display("FAIL frz_exit: busy=%b expected 0", b0); end
    drain_all();
  endtask

  task automatic test_reset_midframe();
    acc_ready = 1'b0;
    begin_frame();
    repeat (3) push(5'd10);
    checks++; if (acc0 !== 8'd30) begin errors++; $display("FAIL rmf_partial: acc=%0d expected 30", acc0); end
    rst = 1'b1;
    #1;
    checks++; if (acc0 !== 8'd0 || b0 !== 1'b0 || v0 !== 1'b0 || o0 !== 1'b0) begin errors++; $display("FAIL rmf_async: acc=%0d busy=%b valid=%b ovf=%b expected 0/0/0/0", acc0, b0, v0, o0); end
    cycle();
    rst = 1'b0;
    push(5'd9);
    checks++; if (b0 !== 1'b0 || acc0 !== 8'd0) begin errors++; $display("FAIL rmf_needs_start: busy=%b acc=%0d expected 0/0", b0, acc0); end
    begin_frame();
    repeat (4) push(5'd2);
    checks++; if (v0 !== 1'b1 || acc0 !== 8'd8) begin errors++; $display("FAIL rmf_new_frame: valid=%b acc=%0d expected 1/8", v0, acc0); end
    drain_all();
  endtask

  task automatic test_ignored();
    acc_ready = 1'b0;
    Q = 5'd31; q_valid = 1'b1;
    cycle(); cycle();
    checks++; if (b0 !== 1'b0 || acc0 !== 8'd8) begin errors++; $display("FAIL ign_idle_q: busy=%b acc=%0d expected 0/8", b0, acc0); end
    start = 1'b1;
    cycle();
    start = 1'b0; q_valid = 1'b0;
    checks++; if (b0 !== 1'b1 || acc0 !== 8'd0) begin errors++; $display("FAIL ign_start_q: busy=%b acc=%0d expected 1/0", b0, acc0); end
    push(5'd3);
    start = 1'b1;
    push(5'd4);
    start = 1'b0;
    push(5'd7); push(5'd1);
    checks++; if (v0 !== 1'b1 || acc0 !== 8'd15) begin errors++; $display("FAIL ign_total: valid=%b acc=%0d expected 1/15", v0, acc0); end
    drain_all();
  endtask

  // Frame-level model: the total is the plain integer sum of samples presented while
  // enable and q_valid are both high; the frame completes on the fourth such sample.
  task automatic test_random();
    for (int f = 0; f < 20; f++) begin
      int         exp_sum = 0;
      int         n = 0;
      int         budget = 0;
      bit         hs = 1'b0;
      bit         released = 1'b0;
      logic [7:0] e0;
      logic [5:0] e1;
      acc_ready = 1'b0;
      begin_frame();
      while (n < 4 && budget < 300) begin
        enable    = ($urandom_range(0, 3) != 0);
        q_valid   = $urandom_range(0, 1);
        Q         = 5'($urandom_range(0, 31));
        acc_ready = $urandom_range(0, 1);
        cycle();
        budget++;
        if (enable && q_valid) begin exp_sum += int'(Q); n++; end
        e0 = exp_sum[7:0]; e1 = exp_sum[5:0];
        checks++; if (acc0 !== e0 || acc1 !== e1 || v0 !== (n == 4)) begin errors++; $display("FAIL rnd_accum f%0d: acc0=%0d acc1=%0d valid=%b expected %0d/%0d/%b", f, acc0, acc1, v0, e0, e1, n == 4); end
      end
      checks++; if (budget >= 300) begin errors++; $display("FAIL rnd_accum_timeout f%0d: samples=%0d required 4", f, n); end
      checks++; if (o0 !== (exp_sum > 255) || o1 !== (exp_sum > 63)) begin errors++; $display("FAIL rnd_ovf f%0d: o0=%b o1=%b expected %b/%b", f, o0, o1, exp_sum > 255, exp_sum > 63); end
      budget = 0;
      while (!released && budget < 100) begin
        enable    = ($urandom_range(0, 3) != 0);
        acc_ready = $urandom_range(0, 1);
        q_valid   = $urandom_range(0, 1);
        Q         = 5'($urandom_range(0, 31));
        hs = enable && acc_ready;
        cycle();
        budget++;
        if (hs) begin
          released = 1'b1;
          checks++; if (b0 !== 1'b0 || v0 !== 1'b0 || acc0 !== e0) begin errors++; $display("FAIL rnd_release f%0d: busy=%b valid=%b acc=%0d expected 0/0/%0d", f, b0, v0, acc0, e0); end
        end else begin
          checks++; if (v0 !== 1'b1 || acc0 !== e0) begin errors++; $display("FAIL rnd_hold f%0d: valid=%b acc=%0d expected 1/%0d", f, v0, acc0, e0); end
        end
      end
      checks++; if (!released) begin errors++; $display("FAIL rnd_done_timeout f%0d: handshake not seen", f); end
      drain_all();
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_overflow();
    test_backpressure();
    test_enable_freeze();
    test_reset_midframe();
    test_ignored();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
